// File: rtl/rd_pix_pkg.sv
// Shared types and constants for the read-side pixel output path.
package rd_pix_pkg;

    // Frame-level control states of the pixel output sequencer.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_ACTIVE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Default raster geometry and pixel format (720p, RGB565).
    localparam int          DEF_H_ACT       = 1280;
    localparam int          DEF_V_ACT       = 720;
    localparam int          DEF_PIX_W       = 16;
    localparam int          DEF_WORD_W      = 2 * DEF_PIX_W;
    localparam logic [15:0] DEF_BLANK_COLOR = 16'h0000;

    // Words in one frame: two pixels are packed per FIFO word.
    localparam int FRAME_WORDS = DEF_H_ACT * DEF_V_ACT / 2;
    localparam int FWC_W       = $clog2(FRAME_WORDS + 1);

    // Width of the saturating underflow pixel counter.
    localparam int UCNT_W = 16;

    // Words per frame for an arbitrary geometry, used by parameterised tops.
    function automatic int calc_frame_words(input int h_act, input int v_act);
        return h_act * v_act / 2;
    endfunction

endpackage

// File: rtl/rd_fifo_pixel_out_unpack.sv
// Width converter between the 32-bit FIFO head word and the 16-bit pixel
// stream: keeps the half-word phase, selects the pixel and generates pops.
module rd_pix_unpack
    import rd_pix_pkg::*;
#(
    parameter int                PIX_W       = DEF_PIX_W,
    parameter int                WORD_W      = DEF_WORD_W,
    parameter logic [PIX_W-1:0]  BLANK_COLOR = PIX_W'(DEF_BLANK_COLOR)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              take_i,
    input  logic              fifo_vld_i,
    input  logic [WORD_W-1:0] fifo_data_i,
    output logic [PIX_W-1:0]  pix_o,
    output logic              pop_o,
    output logic              underflow_o
);

    logic phase_q;
    logic phase_d;

    // Phase advances on every consumed pixel slot, even an underflowing one,
    // so the half-word order stays locked to screen position; only frame
    // start brings it back to the low half.
    always_comb begin
        phase_d = phase_q;
        if (clear_i) begin
            phase_d = 1'b0;
        end else if (take_i) begin
            phase_d = ~phase_q;
        end
    end

    // Phase register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Half-word select; a word is popped only after its high half is shown,
    // and never while the head word is invalid.
    always_comb begin
        pix_o       = BLANK_COLOR;
        pop_o       = 1'b0;
        underflow_o = 1'b0;
        if (take_i) begin
            if (fifo_vld_i) begin
                pix_o = phase_q ? fifo_data_i[WORD_W-1:PIX_W] : fifo_data_i[PIX_W-1:0];
                pop_o = phase_q;
            end else begin
                underflow_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rd_fifo_pixel_out.sv
// Read-side consumer of the prefetch FIFO: unpacks words into pixels aligned
// to the display timing, requests frame fetches and flags underflow.
module rd_fifo_pixel_out
    import rd_pix_pkg::*;
#(
    parameter int               H_ACT       = DEF_H_ACT,
    parameter int               V_ACT       = DEF_V_ACT,
    parameter int               PIX_W       = DEF_PIX_W,
    parameter int               WORD_W      = 2 * PIX_W,
    parameter logic [PIX_W-1:0] BLANK_COLOR = PIX_W'(DEF_BLANK_COLOR)
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              vs_in,
    input  logic              hs_in,
    input  logic              de_in,
    output logic              fifo_rd_en,
    input  logic              fifo_rd_vld,
    input  logic [WORD_W-1:0] fifo_rd_data,
    output logic              frame_req,
    output logic              resync_req,
    output logic              vs_out,
    output logic              hs_out,
    output logic              de_out,
    output logic [PIX_W-1:0]  pix_out,
    output logic              underflow,
    output logic [UCNT_W-1:0] underflow_cnt
);

    localparam int NUM_WORDS = calc_frame_words(H_ACT, V_ACT);
    localparam int WCNT_W    = $clog2(NUM_WORDS + 1);

    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(NUM_WORDS);
    localparam logic [UCNT_W-1:0] UCNT_MAX  = {UCNT_W{1'b1}};

    state_t              state_q;
    state_t              state_d;
    logic                vs_d_q;
    logic [WCNT_W-1:0]   wcnt_q;
    logic [WCNT_W-1:0]   wcnt_d;
    logic [UCNT_W-1:0]   urun_q;
    logic [UCNT_W-1:0]   urun_d;
    logic [UCNT_W-1:0]   ucnt_q;
    logic [UCNT_W-1:0]   ucnt_d;
    logic                uflag_q;
    logic                uflag_d;
    logic                frame_req_q;
    logic                resync_req_q;
    logic                vs_out_q;
    logic                hs_out_q;
    logic                de_out_q;
    logic [PIX_W-1:0]    pix_out_q;

    logic                vs_rise;
    logic                frame_start;
    logic                take;
    logic                pop;
    logic                uf_pix;
    logic [PIX_W-1:0]    pix_sel;

    // A new vs edge outranks any pixel on the same cycle, so that pixel is
    // neither consumed nor counted as underflow.
    always_comb begin
        vs_rise = vs_in & ~vs_d_q;
        take    = (state_q == S_ACTIVE) & de_in & ~vs_rise & (wcnt_q != WCNT_LAST);
    end

    rd_pix_unpack #(
        .PIX_W       (PIX_W),
        .WORD_W      (WORD_W),
        .BLANK_COLOR (BLANK_COLOR)
    ) u_unpack (
        .clk_i       (rd_clk),
        .rst_i       (rd_rst),
        .clear_i     (frame_start),
        .take_i      (take),
        .fifo_vld_i  (fifo_rd_vld),
        .fifo_data_i (fifo_rd_data),
        .pix_o       (pix_sel),
        .pop_o       (pop),
        .underflow_o (uf_pix)
    );

    assign fifo_rd_en = pop;

    // Frame sequencer: every vs edge restarts a fetch, even mid-frame, and a
    // frame that has consumed all its words parks in S_DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (vs_rise) state_d = S_REQ;
            end
            S_REQ: begin
                state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (vs_rise) begin
                    state_d = S_REQ;
                end else if (wcnt_d == WCNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (vs_rise) state_d = S_REQ;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        frame_start = (state_d == S_REQ) && (state_q != S_REQ);
    end

    // Word and underflow bookkeeping; the finished frame's count is latched
    // at frame start while the running count and sticky flag restart.
    always_comb begin
        wcnt_d  = wcnt_q;
        urun_d  = urun_q;
        ucnt_d  = ucnt_q;
        uflag_d = uflag_q;
        if (frame_start) begin
            wcnt_d  = '0;
            urun_d  = '0;
            ucnt_d  = urun_q;
            uflag_d = 1'b0;
        end else begin
            if (pop) begin
                wcnt_d = wcnt_q + 1'b1;
            end
            if (uf_pix) begin
                uflag_d = 1'b1;
                if (urun_q != UCNT_MAX) begin
                    urun_d = urun_q + 1'b1;
                end
            end
        end
    end

    // State, counters and all registered outputs; the timing signals and the
    // pixel share one register stage so they stay aligned downstream.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q      <= S_IDLE;
            vs_d_q       <= 1'b0;
            wcnt_q       <= '0;
            urun_q       <= '0;
            ucnt_q       <= '0;
            uflag_q      <= 1'b0;
            frame_req_q  <= 1'b0;
            resync_req_q <= 1'b0;
            vs_out_q     <= 1'b0;
            hs_out_q     <= 1'b0;
            de_out_q     <= 1'b0;
            pix_out_q    <= '0;
        end else begin
            state_q      <= state_d;
            vs_d_q       <= vs_in;
            wcnt_q       <= wcnt_d;
            urun_q       <= urun_d;
            ucnt_q       <= ucnt_d;
            uflag_q      <= uflag_d;
            frame_req_q  <= frame_start;
            resync_req_q <= frame_start & uflag_q;
            vs_out_q     <= vs_in;
            hs_out_q     <= hs_in;
            de_out_q     <= de_in;
            pix_out_q    <= pix_sel;
        end
    end

    assign frame_req     = frame_req_q;
    assign resync_req    = resync_req_q;
    assign vs_out        = vs_out_q;
    assign hs_out        = hs_out_q;
    assign de_out        = de_out_q;
    assign pix_out       = pix_out_q;
    assign underflow     = uflag_q;
    assign underflow_cnt = ucnt_q;

endmodule
